// File: rtl/serial_pkg.sv
// Shared definitions for both ends of the serial byte link: frame width,
// default bit order and the transmit FSM state type.
package serial_pkg;

  localparam int unsigned SERIAL_DATA_WIDTH = 8;
  localparam bit          SERIAL_MSB_FIRST  = 1'b1;

  typedef enum logic {
    IDLE,
    SHIFT
  } tx_state_t;

endpackage

// File: rtl/serializador_if.sv
// Core-side parallel handshake: the core offers data_in with data_valid,
// the serializer accepts on a clock edge when ready_out is also high.
interface serializador_if
  import serial_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = SERIAL_DATA_WIDTH
);

  logic [DATA_WIDTH-1:0] data_in;
  logic                  data_valid;
  logic                  ready_out;

  modport master (
    output data_in,
    output data_valid,
    input  ready_out
  );

  modport slave (
    input  data_in,
    input  data_valid,
    output ready_out
  );

endinterface

// File: rtl/serial_fifo.sv
// Synchronous FIFO with first-word fall-through read. Pushes while full and
// pops while empty are ignored; a simultaneous push and pop keeps the count.
module serial_fifo #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [DATA_WIDTH-1:0]    push_data,
  input  logic                     pop,
  output logic [DATA_WIDTH-1:0]    pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic                  push_ok;
  logic                  pop_ok;

  assign full     = (count == FULL_COUNT);
  assign empty    = (count == '0);
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Storage array: written only on an accepted push.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/serializador.sv
// Parallel-to-serial transmitter: buffers core words in a FIFO and strobes
// them out one bit per write_out, pausing while the far end reports busy.
module serializador
  import serial_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = SERIAL_DATA_WIDTH,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter bit          MSB_FIRST  = SERIAL_MSB_FIRST
) (
  input  logic            clock,
  input  logic            reset,
  serializador_if.slave   core,
  input  logic            rx_busy,
  output logic            data_out,
  output logic            write_out,
  output logic            status_out,
  output logic            frame_done
);

  localparam int unsigned CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(DATA_WIDTH - 1);

  tx_state_t             state;
  tx_state_t             state_next;
  logic [DATA_WIDTH-1:0] shreg;
  logic [DATA_WIDTH-1:0] shreg_next;
  logic [CW-1:0]         cnt;
  logic [CW-1:0]         cnt_next;
  logic                  data_out_next;
  logic                  write_out_next;
  logic                  last_next;
  logic                  last_q;

  logic                  fifo_pop;
  logic [DATA_WIDTH-1:0] fifo_data;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;

  serial_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (core.data_valid),
    .push_data (core.data_in),
    .pop       (fifo_pop),
    .pop_data  (fifo_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign core.ready_out = !fifo_full;

  // Next-state, shift and strobe decode; the last bit reloads from the FIFO
  // on the same edge so consecutive frames run without a gap cycle.
  always_comb begin
    state_next     = state;
    shreg_next     = shreg;
    cnt_next       = cnt;
    data_out_next  = data_out;
    write_out_next = 1'b0;
    last_next      = 1'b0;
    fifo_pop       = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          shreg_next = fifo_data;
          cnt_next   = LAST_IDX;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (!rx_busy) begin
          write_out_next = 1'b1;
          data_out_next  = MSB_FIRST ? shreg[DATA_WIDTH-1] : shreg[0];
          shreg_next     = MSB_FIRST ? (shreg << 1) : (shreg >> 1);
          cnt_next       = cnt - 1'b1;
          if (cnt == '0) begin
            last_next = 1'b1;
            if (!fifo_empty) begin
              fifo_pop   = 1'b1;
              shreg_next = fifo_data;
              cnt_next   = LAST_IDX;
            end else begin
              cnt_next   = '0;
              state_next = IDLE;
            end
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State, datapath and registered outputs; frame_done trails the last strobe by one cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      shreg      <= '0;
      cnt        <= '0;
      data_out   <= 1'b0;
      write_out  <= 1'b0;
      last_q     <= 1'b0;
      frame_done <= 1'b0;
      status_out <= 1'b0;
    end else begin
      state      <= state_next;
      shreg      <= shreg_next;
      cnt        <= cnt_next;
      data_out   <= data_out_next;
      write_out  <= write_out_next;
      last_q     <= last_next;
      frame_done <= last_q;
      status_out <= (state == SHIFT) || (fifo_count != '0);
    end
  end

endmodule

// File: tb/tb_serializador.sv
// Bench for serializador: one MSB-first and one LSB-first instance, checked
// against a word-level model of the expected bit stream.
module tb_serializador;
  import serial_pkg::*;

  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  serializador_if #(.DATA_WIDTH(DW)) bus_m ();
  serializador_if #(.DATA_WIDTH(DW)) bus_l ();

  logic rx_busy_m, data_out_m, write_out_m, status_m, fd_m;
  logic rx_busy_l, data_out_l, write_out_l, status_l, fd_l;

  serializador #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .MSB_FIRST(1'b1)) dut_m (
    .clock(clock), .reset(reset), .core(bus_m), .rx_busy(rx_busy_m),
    .data_out(data_out_m), .write_out(write_out_m), .status_out(status_m),
    .frame_done(fd_m)
  );

  serializador #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .MSB_FIRST(1'b0)) dut_l (
    .clock(clock), .reset(reset), .core(bus_l), .rx_busy(rx_busy_l),
    .data_out(data_out_l), .write_out(write_out_l), .status_out(status_l),
    .frame_done(fd_l)
  );

  int unsigned cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  bit          obs_m[$];
  int unsigned scyc_m[$];
  int unsigned fdcyc_m[$];
  bit          obs_l[$];
  int unsigned n_fd_l = 0;
  int unsigned busy_viol = 0;
  int          passed = 0;
  int          total  = 0;

  // Monitor: records every strobed bit and frame_done pulse at the falling edge.
  always @(negedge clock) begin
    if (!reset) begin
      if (write_out_m) begin
        obs_m.push_back(data_out_m);
        scyc_m.push_back(cyc);
        if (rx_busy_m) busy_viol++;
      end
      if (fd_m) fdcyc_m.push_back(cyc);
      if (write_out_l) obs_l.push_back(data_out_l);
      if (fd_l) n_fd_l++;
    end
  end

  // Expected i-th transmitted bit of word w.
  function automatic bit model_bit(input logic [DW-1:0] w, input int unsigned i, input bit msb_first);
    int unsigned v;
    v = int'(w);
    return msb_first ? bit'((v >> (DW - 1 - i)) & 1) : bit'((v >> i) & 1);
  endfunction

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic clear_obs();
    obs_m.delete(); scyc_m.delete(); fdcyc_m.delete(); obs_l.delete();
    n_fd_l = 0; busy_viol = 0;
  endtask

  task automatic push(input bit lsb, input logic [DW-1:0] w, output int unsigned sc);
    sc = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (lsb ? bus_l.ready_out : bus_m.ready_out) begin
        if (lsb) begin bus_l.data_valid = 1'b1; bus_l.data_in = w; end
        else     begin bus_m.data_valid = 1'b1; bus_m.data_in = w; end
        sc = cyc;
        return;
      end
      if (lsb) bus_l.data_valid = 1'b0; else bus_m.data_valid = 1'b0;
    end
    total++;
    $display("FAIL push_timeout: ready_out never rose, required 1 within 300 cycles");
  endtask

  task automatic release_in();
    tick();
    bus_m.data_valid = 1'b0;
    bus_l.data_valid = 1'b0;
  endtask

  task automatic wait_bits(input bit lsb, input int unsigned n, input string name);
    for (int i = 0; i < 600 && (lsb ? obs_l.size() : obs_m.size()) < n; i++) tick();
    total++;
    if ((lsb ? obs_l.size() : obs_m.size()) < n)
      $display("FAIL %s_bits_timeout: got %0d bits, required %0d", name,
               lsb ? obs_l.size() : obs_m.size(), n);
    else passed++;
    repeat (4) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus_m.data_valid = 1'b0; bus_m.data_in = '0; rx_busy_m = 1'b0;
    bus_l.data_valid = 1'b0; bus_l.data_in = '0; rx_busy_l = 1'b0;
    repeat (3) tick();
    total++; if (data_out_m !== 1'b0) $display("FAIL rst_data_out: got %b required 0", data_out_m); else passed++;
    total++; if (write_out_m !== 1'b0) $display("FAIL rst_write_out: got %b required 0", write_out_m); else passed++;
    total++; if (status_m !== 1'b0) $display("FAIL rst_status: got %b required 0", status_m); else passed++;
    total++; if (fd_m !== 1'b0) $display("FAIL rst_frame_done: got %b required 0", fd_m); else passed++;
    total++; if (bus_m.ready_out !== 1'b1) $display("FAIL rst_ready: got %b required 1", bus_m.ready_out); else passed++;
    total++; if (bus_l.ready_out !== 1'b1) $display("FAIL rst_ready_l: got %b required 1", bus_l.ready_out); else passed++;
    reset = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_single();
    int unsigned sc;
    logic [DW-1:0] w;
    w = 8'hA5;
    clear_obs();
    push(1'b0, w, sc);
    release_in();
    wait_bits(1'b0, DW, "single");
    total++; if (obs_m.size() != DW) $display("FAIL single_count: got %0d bits required %0d", obs_m.size(), DW); else passed++;
    if (obs_m.size() == DW) begin
      for (int unsigned i = 0; i < DW; i++) begin
        total++;
        if (obs_m[i] !== model_bit(w, i, 1'b1))
          $display("FAIL single_bit%0d: got %b required %b", i, obs_m[i], model_bit(w, i, 1'b1));
        else passed++;
      end
      total++; if (scyc_m[0] != sc + 3) $display("FAIL single_latency: first strobe cycle %0d required %0d", scyc_m[0], sc + 3); else passed++;
      total++; if (scyc_m[DW-1] - scyc_m[0] != DW - 1) $display("FAIL single_contiguous: span %0d required %0d", scyc_m[DW-1] - scyc_m[0], DW - 1); else passed++;
      total++; if (fdcyc_m.size() != 1 || fdcyc_m[0] != scyc_m[DW-1] + 1)
        $display("FAIL single_frame_done: %0d pulses first at %0d, required 1 at %0d", fdcyc_m.size(), fdcyc_m.size() ? fdcyc_m[0] : 0, scyc_m[DW-1] + 1);
      else passed++;
    end
    total++; if (status_m !== 1'b0) $display("FAIL single_status_idle: got %b required 0", status_m); else passed++;
  endtask

  task automatic test_back_to_back();
    int unsigned sc;
    logic [DW-1:0] w [2];
    w[0] = 8'h3C; w[1] = 8'hFF;
    clear_obs();
    push(1'b0, w[0], sc);
    push(1'b0, w[1], sc);
    release_in();
    wait_bits(1'b0, 2 * DW, "b2b");
    total++; if (obs_m.size() != 2 * DW) $display("FAIL b2b_count: got %0d required %0d", obs_m.size(), 2 * DW); else passed++;
    if (obs_m.size() == 2 * DW) begin
      for (int unsigned k = 0; k < 2; k++) begin
        int unsigned bad = 0;
        for (int unsigned i = 0; i < DW; i++)
          if (obs_m[k*DW+i] !== model_bit(w[k], i, 1'b1)) bad++;
        total++; if (bad != 0) $display("FAIL b2b_word%0d: %0d wrong bits, required 0 (word %h)", k, bad, w[k]); else passed++;
      end
      total++; if (scyc_m[2*DW-1] - scyc_m[0] != 2 * DW - 1) $display("FAIL b2b_gapless: span %0d required %0d", scyc_m[2*DW-1] - scyc_m[0], 2 * DW - 1); else passed++;
      total++; if (fdcyc_m.size() != 2 || fdcyc_m[1] - fdcyc_m[0] != DW || fdcyc_m[0] != scyc_m[DW-1] + 1)
        $display("FAIL b2b_frame_done: %0d pulses, required 2 spaced %0d", fdcyc_m.size(), DW);
      else passed++;
    end
  endtask

  task automatic test_stall();
    int unsigned sc;
    logic [DW-1:0] w;
    w = 8'h81;
    clear_obs();
    push(1'b0, w, sc);
    release_in();
    for (int i = 0; i < 50 && obs_m.size() < 2; i++) tick();
    rx_busy_m = 1'b1;
    for (int unsigned s = 0; s < 3; s++) begin
      tick();
      total++; if (write_out_m !== 1'b0) $display("FAIL stall_write_out%0d: got %b required 0", s, write_out_m); else passed++;
      total++; if (data_out_m !== model_bit(w, 1, 1'b1)) $display("FAIL stall_hold%0d: got %b required %b", s, data_out_m, model_bit(w, 1, 1'b1)); else passed++;
    end
    rx_busy_m = 1'b0;
    wait_bits(1'b0, DW, "stall");
    total++; if (obs_m.size() != DW) $display("FAIL stall_count: got %0d required %0d", obs_m.size(), DW); else passed++;
    if (obs_m.size() == DW) begin
      int unsigned bad = 0;
      for (int unsigned i = 0; i < DW; i++) if (obs_m[i] !== model_bit(w, i, 1'b1)) bad++;
      total++; if (bad != 0) $display("FAIL stall_sequence: %0d wrong bits required 0", bad); else passed++;
      total++; if (scyc_m[2] - scyc_m[1] != 4) $display("FAIL stall_gap: got %0d cycles required 4", scyc_m[2] - scyc_m[1]); else passed++;
    end
    total++; if (busy_viol != 0) $display("FAIL stall_busy_strobe: got %0d strobes while busy required 0", busy_viol); else passed++;
  endtask

  task automatic test_full();
    int unsigned acc [6];
    logic [DW-1:0] w [6];
    int unsigned ready_seen = 0;
    for (int unsigned k = 0; k < 6; k++) w[k] = DW'($urandom);
    clear_obs();
    rx_busy_m = 1'b1;
    // Capacity while stalled is the FIFO plus the word already in the shift register.
    for (int unsigned k = 0; k < DEPTH + 1; k++) push(1'b0, w[k], acc[k]);
    release_in();
    total++; if (acc[DEPTH] - acc[0] != DEPTH) $display("FAIL full_accept_rate: span %0d required %0d", acc[DEPTH] - acc[0], DEPTH); else passed++;
    total++; if (bus_m.ready_out !== 1'b0) $display("FAIL full_ready_low: got %b required 0", bus_m.ready_out); else passed++;
    repeat (10) begin tick(); if (bus_m.ready_out) ready_seen++; end
    total++; if (ready_seen != 0) $display("FAIL full_ready_held: ready high %0d cycles required 0", ready_seen); else passed++;
    total++; if (obs_m.size() != 0) $display("FAIL full_no_strobe: got %0d bits required 0", obs_m.size()); else passed++;
    rx_busy_m = 1'b0;
    push(1'b0, w[DEPTH+1], acc[DEPTH+1]);
    total++; if (obs_m.size() != DW) $display("FAIL full_accept_after_pop: %0d bits out at accept, required %0d", obs_m.size(), DW); else passed++;
    release_in();
    wait_bits(1'b0, 6 * DW, "full");
    for (int unsigned k = 0; k < 6; k++) begin
      logic [DW-1:0] got;
      got = '0;
      for (int unsigned i = 0; i < DW && k*DW+i < obs_m.size(); i++)
        got = got | (DW'(obs_m[k*DW+i]) << (DW - 1 - i));
      total++; if (got !== w[k]) $display("FAIL full_word%0d: got %h required %h", k, got, w[k]); else passed++;
    end
    total++; if (fdcyc_m.size() != 6) $display("FAIL full_frame_done: got %0d pulses required 6", fdcyc_m.size()); else passed++;
  endtask

  task automatic test_reset_mid();
    int unsigned sc;
    logic [DW-1:0] w;
    w = 8'hC3;
    clear_obs();
    push(1'b0, w, sc);
    push(1'b0, 8'h11, sc);
    push(1'b0, 8'h22, sc);
    release_in();
    for (int i = 0; i < 50 && obs_m.size() < 4; i++) tick();
    reset = 1'b1;
    #1;
    total++; if (write_out_m !== 1'b0) $display("FAIL rmid_write_out: got %b required 0", write_out_m); else passed++;
    total++; if (status_m !== 1'b0) $display("FAIL rmid_status: got %b required 0", status_m); else passed++;
    total++; if (bus_m.ready_out !== 1'b1) $display("FAIL rmid_ready: got %b required 1", bus_m.ready_out); else passed++;
    repeat (2) tick();
    reset = 1'b0;
    repeat (20) tick();
    total++; if (obs_m.size() != 4) $display("FAIL rmid_discard: got %0d bits required 4", obs_m.size()); else passed++;
    total++; if (fdcyc_m.size() != 0) $display("FAIL rmid_no_frame_done: got %0d pulses required 0", fdcyc_m.size()); else passed++;
    if (obs_m.size() >= 4) begin
      int unsigned bad = 0;
      for (int unsigned i = 0; i < 4; i++) if (obs_m[i] !== model_bit(w, i, 1'b1)) bad++;
      total++; if (bad != 0) $display("FAIL rmid_partial: %0d wrong bits required 0", bad); else passed++;
    end
    w = 8'h5A;
    clear_obs();
    push(1'b0, w, sc);
    release_in();
    wait_bits(1'b0, DW, "after_reset");
    begin
      logic [DW-1:0] got;
      got = '0;
      for (int unsigned i = 0; i < DW && i < obs_m.size(); i++) got = got | (DW'(obs_m[i]) << (DW - 1 - i));
      total++; if (got !== w || obs_m.size() != DW) $display("FAIL rmid_new_word: got %h (%0d bits) required %h", got, obs_m.size(), w); else passed++;
    end
    total++; if (fdcyc_m.size() != 1) $display("FAIL rmid_new_frame_done: got %0d required 1", fdcyc_m.size()); else passed++;
  endtask

  task automatic test_lsb_first();
    int unsigned sc;
    logic [DW-1:0] w;
    w = 8'h01;
    clear_obs();
    push(1'b1, w, sc);
    release_in();
    wait_bits(1'b1, DW, "lsb");
    total++; if (obs_l.size() != DW) $display("FAIL lsb_count: got %0d required %0d", obs_l.size(), DW); else passed++;
    if (obs_l.size() == DW) begin
      for (int unsigned i = 0; i < DW; i++) begin
        total++;
        if (obs_l[i] !== model_bit(w, i, 1'b0))
          $display("FAIL lsb_bit%0d: got %b required %b", i, obs_l[i], model_bit(w, i, 1'b0));
        else passed++;
      end
    end
    total++; if (n_fd_l != 1) $display("FAIL lsb_frame_done: got %0d required 1", n_fd_l); else passed++;
  endtask

  task automatic test_random();
    localparam int unsigned N = 24;
    logic [DW-1:0] exp_q[$];
    int unsigned sent = 0;
    clear_obs();
    for (int i = 0; i < 4000 && (sent < N || obs_m.size() < N * DW); i++) begin
      tick();
      rx_busy_m = ($urandom_range(0, 9) < 3);
      if (sent < N && bus_m.ready_out && $urandom_range(0, 9) < 6) begin
        logic [DW-1:0] w;
        w = DW'($urandom);
        bus_m.data_valid = 1'b1;
        bus_m.data_in = w;
        exp_q.push_back(w);
        sent++;
      end else begin
        bus_m.data_valid = 1'b0;
      end
    end
    bus_m.data_valid = 1'b0;
    rx_busy_m = 1'b0;
    repeat (4) tick();
    total++; if (obs_m.size() != N * DW) $display("FAIL rand_count: got %0d bits required %0d", obs_m.size(), N * DW); else passed++;
    for (int unsigned k = 0; k < exp_q.size(); k++) begin
      logic [DW-1:0] got;
      got = '0;
      for (int unsigned i = 0; i < DW && k*DW+i < obs_m.size(); i++)
        got = got | (DW'(obs_m[k*DW+i]) << (DW - 1 - i));
      total++; if (got !== exp_q[k]) $display("FAIL rand_word%0d: got %h required %h", k, got, exp_q[k]); else passed++;
    end
    total++; if (fdcyc_m.size() != N) $display("FAIL rand_frame_done: got %0d required %0d", fdcyc_m.size(), N); else passed++;
    total++; if (busy_viol != 0) $display("FAIL rand_busy_strobe: got %0d required 0", busy_viol); else passed++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_full();
    test_reset_mid();
    test_lsb_first();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, required finish before 2ms");
    $fatal(1);
  end

endmodule
